mysoc_rr_read_arbiter: RTL and testbench
========================================

// Module: mysoc_rr_read_arbiter
// PURPOSE
// - Shares one read-only Avalon-MM slave (sysid-class register slave) between two read masters.
// - Round-robin grant; one outstanding transaction; returns data via readdatavalid pulse.
// - Sits in MySoc between the CPU data master and a secondary master (e.g. debug/boot checker) and the slave.
// PARAMETERS
// - ADDR_W        1   slave address width (bits)
// - DATA_W        32  readdata width (bits)
// - READ_LATENCY  0   slave cycles from s_read to valid s_readdata (0 = combinational slave), range 0..7
// PORTS
// - clock             in   1       single clock, all flops rising edge
// - reset_n           in   1       asynchronous, active-low reset
// - m0_address        in   ADDR_W  master 0 word address
// - m0_read           in   1       master 0 read request; held until m0_waitrequest==0
// - m0_waitrequest    out  1       master 0 stall
// - m0_readdata       out  DATA_W  master 0 read data, valid only with m0_readdatavalid
// - m0_readdatavalid  out  1       master 0 one-cycle data strobe
// - m1_*              --   --      identical set for master 1
// - s_address         out  ADDR_W  slave address (registered)
// - s_read            out  1       slave read strobe (registered)
// - s_readdata        in   DATA_W  slave read data
// BEHAVIOUR
// - Reset (async): state=IDLE; s_read=0; s_address=0; both readdatavalid=0; both readdata=0; last_grant=1 (m0 wins first tie).
// - m*_waitrequest combinational: = mX_read & ~(state==IDLE & winner==X). Never asserted when mX_read=0.
// - FSM IDLE -> ISSUE -> WAIT (only if READ_LATENCY>0) -> RESP -> IDLE.
// - IDLE: winner = sole requester, or on tie the master != last_grant. Accept cycle: latch address and winner id,
//   update last_grant, go ISSUE. No request: stay IDLE.
// - ISSUE: s_read=1 one cycle, s_address=latched address. READ_LATENCY==0: capture s_readdata this cycle -> RESP;
//   else load counter=READ_LATENCY-1 -> WAIT.
// - WAIT: s_read=0; decrement; capture s_readdata when counter==0 -> RESP.
// - RESP: winner's readdatavalid=1 and readdata=captured word for exactly one cycle; other master's valid=0 -> IDLE.
// - Latency: accept at cycle N -> readdatavalid at N+2+READ_LATENCY. Throughput 1 read per 3+READ_LATENCY cycles.
// - Non-winner keeps waitrequest=1 for the whole transaction; its request is served at the next IDLE (no starvation:
//   with both continuously requesting, grants alternate m0,m1,m0,...).
// - Master dropping read while stalled: no transaction, no strobe (protocol violation tolerated, not checked).
// - readdata registers hold last value after RESP; only the strobe qualifies data.
// - Reset asserted mid-transaction: everything returns to reset values immediately; the pending transaction is
//   discarded with no readdatavalid after release.
// - Counter width 3 bits; READ_LATENCY outside 0..7 is a elaboration error ($error in generate).
// STRUCTURE
// - Shared package/include mysoc_arb_defs: FSM state localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3),
//   master id localparams M0=1'b0, M1=1'b1.
// - One sub-module: mysoc_rr_pick (combinational: req[1:0], last_grant -> valid, winner).
// - Top holds FSM, latency counter, address/winner/readdata registers and output muxing.
// TESTING (slave model: addr 1 -> 32'h622B_8162, addr 0 -> 32'h0, parametrised latency)
// - Reset: hold reset_n=0 3 cycles with both reads high -> s_read=0, valids=0, readdata=0, both waitrequest=1.
// - Single read, LAT=0: m0 addr 1 at cycle N -> m0_waitrequest=0 at N, s_read=1 at N+1,
//   m0_readdatavalid=1 with 32'h622B_8162 at N+2, m1 strobes stay 0.
// - Tie: m0 and m1 both read addr 1/0 at same cycle -> m0 granted first (data 32'h622B_8162), m1 next (32'h0);
//   continuous requests alternate m0,m1,m0,m1 over 8 transactions.
// - Latency: LAT=3, m1 reads addr 1 -> readdatavalid exactly 5 cycles after accept, s_read high one cycle only.
// - Reset mid-op: assert reset_n=0 during WAIT -> outputs at reset values same cycle; no strobe after release;
//   next request completes normally with m0 priority.
// - Back-to-back single master: m1 holds read for 4 transactions -> one strobe every 3 cycles (LAT=0), no gaps lost.

Source files
------------

// File: rtl/mysoc_arb_defs_pkg.sv
// -----------------------------------------------------------------------------
// mysoc_arb_defs
// Shared definitions for the MySoc two-master read arbiter:
//   - arb_state_e : arbiter FSM encoding (IDLE/ISSUE/WAIT/RESP)
//   - M0, M1      : master identifiers used for winner / last_grant tracking
//   - CNT_W       : width of the slave-latency down-counter
// -----------------------------------------------------------------------------
package mysoc_arb_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int CNT_W = 3;

endpackage : mysoc_arb_defs

// File: rtl/mysoc_rr_pick.sv
// -----------------------------------------------------------------------------
// mysoc_rr_pick
// Combinational round-robin pick between two requesters.
//   req[1:0]    in   request vector, bit i = master i
//   last_grant  in   master granted most recently
//   valid       out  at least one request present
//   winner      out  sole requester, or on a tie the master that did not win last
// -----------------------------------------------------------------------------
module mysoc_rr_pick
  import mysoc_arb_defs::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  // NOTE: every output of a combinational block is given a default before the
  // case so that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    valid  = |req;
    winner = M0;
    case (req)
      2'b01:   winner = M0;
      2'b10:   winner = M1;
      2'b11:   winner = ~last_grant;
      default: winner = M0;
    endcase
  end

endmodule : mysoc_rr_pick

// File: rtl/mysoc_rr_read_arbiter.sv
// -----------------------------------------------------------------------------
// mysoc_rr_read_arbiter
// Shares one read-only Avalon-MM slave between two read masters. Round-robin
// grant, one outstanding transaction, data returned with a one-cycle
// readdatavalid strobe to the winning master.
//
// Parameters
//   ADDR_W        slave address width
//   DATA_W        read data width
//   READ_LATENCY  slave cycles from s_read to valid s_readdata (0..7)
//
// Ports
//   clock, reset_n                  clock / asynchronous active-low reset
//   m0_address, m0_read             master 0 request (read held while stalled)
//   m0_waitrequest                  master 0 stall (combinational)
//   m0_readdata, m0_readdatavalid   master 0 response (data qualified by strobe)
//   m1_*                            identical set for master 1
//   s_address, s_read               registered slave request
//   s_readdata                      slave read data
// -----------------------------------------------------------------------------
module mysoc_rr_read_arbiter
  import mysoc_arb_defs::*;
#(
  parameter int ADDR_W       = 1,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 0
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  input  logic [DATA_W-1:0] s_readdata
);

  if (READ_LATENCY < 0 || READ_LATENCY > 7) begin : g_bad_latency
    $error("mysoc_rr_read_arbiter: READ_LATENCY must be in 0..7");
  end

  // Counter is loaded in ISSUE and reaches zero on the cycle the slave data is valid.
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (READ_LATENCY > 0) ? CNT_W'(READ_LATENCY - 1) : '0;

  arb_state_e       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             win_q;
  logic             last_grant;
  logic             pick_valid;
  logic             pick_winner;
  logic             accept;
  logic             capture;

  mysoc_rr_pick u_pick (
    .req        ({m1_read, m0_read}),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // reset_n gates the grant so that no master sees waitrequest low while the
  // arbiter is held in reset.
  assign accept  = reset_n && (state == IDLE) && pick_valid;

  assign capture = ((state == ISSUE) && (READ_LATENCY == 0)) ||
                   ((state == WAIT)  && (cnt == '0));

  assign m0_waitrequest   = m0_read && !(accept && (pick_winner == M0));
  assign m1_waitrequest   = m1_read && !(accept && (pick_winner == M1));

  assign m0_readdatavalid = (state == RESP) && (win_q == M0);
  assign m1_readdatavalid = (state == RESP) && (win_q == M1);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: flops are written with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = (READ_LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: slave request, latency counter, grant tracking, response data
  // ---------------------------------------------------------------------------
  // NOTE: the readdata registers are reset as well as the control flops; they
  // are visible ports with defined reset values, not internal storage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_read      <= 1'b0;
      s_address   <= '0;
      win_q       <= M0;
      last_grant  <= M1;
      cnt         <= '0;
      m0_readdata <= '0;
      m1_readdata <= '0;
    end else begin
      // s_read is high exactly in the ISSUE cycle following an accept.
      s_read <= accept;

      if (accept) begin
        s_address  <= (pick_winner == M1) ? m1_address : m0_address;
        win_q      <= pick_winner;
        last_grant <= pick_winner;
      end

      if (state == ISSUE)                    cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != '0)   cnt <= cnt - 1'b1;

      // Only the winner's register is loaded; the other keeps its last word.
      if (capture) begin
        if (win_q == M0) m0_readdata <= s_readdata;
        else             m1_readdata <= s_readdata;
      end
    end
  end

endmodule : mysoc_rr_read_arbiter

// File: tb/tb_mysoc_rr_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mysoc_rr_read_arbiter
// Two arbiter instances share clock and reset: index 0 with READ_LATENCY=0 and
// index 1 with READ_LATENCY=3, each in front of its own slave model
// (addr 1 -> 32'h622B_8162, addr 0 -> 32'h0, junk outside the data window).
// Expected responses go into a per-instance queue at accept time and are
// popped by a negedge monitor when the strobe is due.
// -----------------------------------------------------------------------------
module tb_mysoc_rr_read_arbiter;
  import mysoc_arb_defs::*;

  localparam logic [31:0] WORD1 = 32'h622B_8162;
  localparam logic [31:0] WORD0 = 32'h0000_0000;
  localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

  typedef struct {
    bit          m;
    logic [31:0] d;
    int          due;
  } exp_t;

  typedef struct {
    bit          r0;
    bit          a0;
    bit          r1;
    bit          a1;
    bit          ev;
    bit          w;
    logic [31:0] d;
  } vec_t;

  logic             clock;
  logic             reset_n;
  logic [1:0]       m0_addr, m0_read, m0_wait, m0_valid;
  logic [1:0]       m1_addr, m1_read, m1_wait, m1_valid;
  logic [1:0][31:0] m0_rdata, m1_rdata, s_rdata;
  logic [1:0]       s_addr, s_read;

  int   cyc    = 0;
  int   tests  = 0;
  int   failed = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] slave_word(input logic a);
    return a ? WORD1 : WORD0;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : 3;
    logic [7:0]  vpipe = '0;
    logic [31:0] dpipe [8];

    always @(posedge clock) begin
      vpipe    <= {vpipe[6:0], s_read[g]};
      dpipe[0] <= slave_word(s_addr[g]);
      for (int i = 1; i < 8; i++) dpipe[i] <= dpipe[i-1];
    end

    if (LAT == 0) begin : g_comb
      assign s_rdata[g] = s_read[g] ? slave_word(s_addr[g]) : JUNK;
    end else begin : g_pipe
      assign s_rdata[g] = vpipe[LAT-1] ? dpipe[LAT-1] : JUNK;
    end

    mysoc_rr_read_arbiter #(
      .ADDR_W(1), .DATA_W(32), .READ_LATENCY(LAT)
    ) u_dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .m0_address       (m0_addr[g]),
      .m0_read          (m0_read[g]),
      .m0_waitrequest   (m0_wait[g]),
      .m0_readdata      (m0_rdata[g]),
      .m0_readdatavalid (m0_valid[g]),
      .m1_address       (m1_addr[g]),
      .m1_read          (m1_read[g]),
      .m1_waitrequest   (m1_wait[g]),
      .m1_readdata      (m1_rdata[g]),
      .m1_readdatavalid (m1_valid[g]),
      .s_address        (s_addr[g]),
      .s_read           (s_read[g]),
      .s_readdata       (s_rdata[g])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void sb_push(input int d, input bit m, input logic [31:0] data, input int due);
    exp_t e;
    e.m = m; e.d = data; e.due = due;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endfunction

  // Response monitor: a strobe must match the oldest expectation, and an
  // expectation whose due cycle arrives without a strobe is reported.
  task automatic mon(input int d);
    logic [1:0] v;
    int         n;
    exp_t       e;
    v = {m1_valid[d], m0_valid[d]};
    n = (d == 0) ? sb0.size() : sb1.size();
    if (n == 0) begin
      if (v != 2'b00) check($sformatf("unexpected strobe dut%0d", d), v, 0);
    end else begin
      if (d == 0) e = sb0[0];
      else        e = sb1[0];
      if (v != 2'b00 || e.due <= cyc) begin
        if (d == 0) void'(sb0.pop_front());
        else        void'(sb1.pop_front());
        check($sformatf("strobe valid dut%0d", d), v, e.m ? 2'b10 : 2'b01);
        check($sformatf("strobe data dut%0d", d), e.m ? m1_rdata[d] : m0_rdata[d], e.d);
        check($sformatf("strobe cycle dut%0d", d), cyc, e.due);
      end
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      mon(0);
      mon(1);
    end
  end

  // Holds the given read pattern for n transactions, checking waitrequest and
  // s_read every cycle. Grants alternate when both masters request.
  task automatic stream(input int d, input bit r0, input bit r1, input int n,
                        input bit first, input bit a0, input bit a1);
    bit w;
    int lat;
    w   = first;
    lat = (d == 0) ? 0 : 3;
    @(posedge clock); #1;
    m0_read[d] = r0; m0_addr[d] = a0;
    m1_read[d] = r1; m1_addr[d] = a1;
    for (int t = 0; t < n; t++) begin
      @(negedge clock);
      check("accept m0_wait", m0_wait[d], r0 && (w != M0));
      check("accept m1_wait", m1_wait[d], r1 && (w != M1));
      sb_push(d, w, slave_word(w ? a1 : a0), cyc + 2 + lat);
      for (int k = 0; k < 2 + lat; k++) begin
        @(negedge clock);
        check("busy m0_wait", m0_wait[d], r0);
        check("busy m1_wait", m1_wait[d], r1);
        check("s_read pulse", s_read[d], k == 0);
      end
      if (r0 && r1) w = ~w;
    end
    @(posedge clock); #1;
    m0_read[d] = 1'b0;
    m1_read[d] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [9];
    tbl[0] = '{1, 1, 0, 0, 1, M0, WORD1};
    tbl[1] = '{0, 0, 1, 0, 1, M1, WORD0};
    tbl[2] = '{1, 1, 1, 0, 1, M0, WORD1};
    tbl[3] = '{1, 0, 1, 1, 1, M1, WORD1};
    tbl[4] = '{0, 0, 1, 1, 1, M1, WORD1};
    tbl[5] = '{1, 1, 1, 1, 1, M0, WORD1};
    tbl[6] = '{1, 0, 0, 0, 1, M0, WORD0};
    tbl[7] = '{1, 0, 1, 1, 1, M1, WORD1};
    tbl[8] = '{0, 0, 0, 0, 0, M0, WORD0};

    // Reset held three cycles with every read request high.
    reset_n = 1'b1;
    m0_read = 2'b11; m1_read = 2'b11;
    m0_addr = 2'b11; m1_addr = 2'b00;
    #2 reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        check("reset s_read",    s_read[d],   0);
        check("reset s_address", s_addr[d],   0);
        check("reset valids",    {m1_valid[d], m0_valid[d]}, 0);
        check("reset m0_rdata",  m0_rdata[d], 0);
        check("reset m1_rdata",  m1_rdata[d], 0);
        check("reset waits",     {m1_wait[d], m0_wait[d]}, 2'b11);
      end
    end
    @(posedge clock); #1;
    m0_read = 2'b00; m1_read = 2'b00;
    reset_n = 1'b1;

    // Single-transaction vectors on the zero-latency instance.
    for (int i = 0; i < 9; i++) begin
      @(posedge clock); #1;
      m0_read[0] = tbl[i].r0; m0_addr[0] = tbl[i].a0;
      m1_read[0] = tbl[i].r1; m1_addr[0] = tbl[i].a1;
      @(negedge clock);
      check($sformatf("tbl%0d m0_wait", i), m0_wait[0], tbl[i].r0 && !(tbl[i].ev && tbl[i].w == M0));
      check($sformatf("tbl%0d m1_wait", i), m1_wait[0], tbl[i].r1 && !(tbl[i].ev && tbl[i].w == M1));
      if (tbl[i].ev) sb_push(0, tbl[i].w, tbl[i].d, cyc + 2);
      @(posedge clock); #1;
      m0_read[0] = 1'b0;
      m1_read[0] = 1'b0;
      @(negedge clock);
      check($sformatf("tbl%0d s_read", i), s_read[0], tbl[i].ev);
      if (tbl[i].ev)
        check($sformatf("tbl%0d s_address", i), s_addr[0], tbl[i].w ? tbl[i].a1 : tbl[i].a0);
      @(posedge clock);
    end

    // Continuous tie: grants alternate m0, m1, ... over 8 transactions.
    stream(0, 1, 1, 8, M0, 1, 0);
    // One master back-to-back: a strobe every 3 cycles.
    stream(0, 0, 1, 4, M1, 0, 1);
    // Latency-3 instance: strobe 5 cycles after accept.
    stream(1, 0, 1, 1, M1, 0, 1);
    repeat (2) @(posedge clock);
    check("lat3 m1_rdata hold", m1_rdata[1], WORD1);

    // Reset during WAIT on the latency-3 instance discards the transaction.
    @(posedge clock); #1;
    m0_read[1] = 1'b1; m0_addr[1] = 1'b1;
    @(negedge clock);
    check("midrst accept m0_wait", m0_wait[1], 0);
    @(posedge clock); #1;
    m0_read[1] = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("midrst s_read",    s_read[1], 0);
    check("midrst s_address", s_addr[1], 0);
    check("midrst valids",    {m1_valid[1], m0_valid[1]}, 0);
    check("midrst m1_rdata",  m1_rdata[1], 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (8) @(posedge clock);
    // After reset a tie goes to m0 first again.
    stream(1, 1, 1, 2, M0, 1, 0);

    for (int i = 0; i < 20 && (sb0.size() != 0 || sb1.size() != 0); i++) @(posedge clock);
    @(negedge clock);
    check("drain dut0", sb0.size(), 0);
    check("drain dut1", sb1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_mysoc_rr_read_arbiter
